// File: rtl/tea_iterative_encryptor_if.sv
// Handshake bundle for the iterative TEA encryptor: plaintext/key in, ciphertext out.
// The master side is the block feeding plaintext and consuming ciphertext.
interface tea_iterative_encryptor_if;
   logic          in_valid;
   logic          in_ready;
   logic [63:0]   inBlock64;
   logic [127:0]  key;
   logic          out_valid;
   logic          out_ready;
   logic [63:0]   outBlock64;

   modport master (
      output in_valid, inBlock64, key, out_ready,
      input  in_ready, out_valid, outBlock64
   );

   modport slave (
      input  in_valid, inBlock64, key, out_ready,
      output in_ready, out_valid, outBlock64
   );
endinterface

// File: rtl/tea_iterative_encryptor.sv
// Iterative TEA encryptor: one full TEA cycle (both half-rounds) per enabled clock.
// Accepts a block in IDLE, iterates ROUNDS times in RUN, and holds the ciphertext in DONE.
module tea_iterative_encryptor #(
   parameter int unsigned ROUNDS = 32,
   parameter logic [31:0] DELTA  = 32'h9E3779B9
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        ena,
   tea_iterative_encryptor_if.slave    bus
);

   localparam int unsigned            CNT_W    = $clog2(ROUNDS) + 1;
   localparam logic [CNT_W-1:0]       LAST_CNT = CNT_W'(ROUNDS - 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [CNT_W-1:0]  cnt;
   logic [31:0]       sum;
   logic [31:0]       v0;
   logic [31:0]       v1;
   logic [127:0]      key_q;
   logic              out_valid_q;
   logic [63:0]       out_block_q;

   logic              accept;
   logic              step;
   logic              last_round;
   logic              consume;
   logic [31:0]       sum_nxt;
   logic [31:0]       v0_nxt;
   logic [31:0]       v1_nxt;

   assign bus.in_ready   = (state == IDLE) && ena && !rst;
   assign bus.out_valid  = out_valid_q;
   assign bus.outBlock64 = out_block_q;

   assign accept     = bus.in_valid && bus.in_ready;
   assign step       = (state == RUN) && ena;
   assign last_round = step && (cnt == LAST_CNT);
   assign consume    = (state == DONE) && ena && out_valid_q && bus.out_ready;

   // The second half-round consumes the freshly updated v0, so both live in one cycle.
   always_comb begin
      sum_nxt = sum + DELTA;
      v0_nxt  = v0 + (((v1 << 4) + key_q[127:96]) ^ (v1 + sum_nxt) ^ ((v1 >> 5) + key_q[95:64]));
      v1_nxt  = v1 + (((v0_nxt << 4) + key_q[63:32]) ^ (v0_nxt + sum_nxt) ^ ((v0_nxt >> 5) + key_q[31:0]));
   end

   // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (accept)     state_nxt = RUN;
         RUN:     if (last_round) state_nxt = DONE;
         DONE:    if (consume)    state_nxt = IDLE;
         default:                 state_nxt = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // NOTE: the datapath is cleared on reset too, so an aborted block leaves no trace on the outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt         <= '0;
         sum         <= '0;
         v0          <= '0;
         v1          <= '0;
         key_q       <= '0;
         out_valid_q <= 1'b0;
         out_block_q <= '0;
      end else begin
         if (accept) begin
            cnt   <= '0;
            sum   <= '0;
            v0    <= bus.inBlock64[63:32];
            v1    <= bus.inBlock64[31:0];
            key_q <= bus.key;
         end
         if (step) begin
            cnt <= cnt + 1'b1;
            sum <= sum_nxt;
            v0  <= v0_nxt;
            v1  <= v1_nxt;
         end
         if (last_round) begin
            out_valid_q <= 1'b1;
            out_block_q <= {v0_nxt, v1_nxt};
         end
         if (consume) out_valid_q <= 1'b0;
      end
   end

endmodule

// File: tb/tb_tea_iterative_encryptor.sv
// Scoreboard bench for the iterative TEA encryptor: stimulus pushes expected ciphertexts,
// a negedge monitor pops and compares each completed output transfer.
module tb_tea_iterative_encryptor;

   localparam int unsigned ROUNDS = 32;
   localparam logic [31:0] DELTA  = 32'h9E3779B9;
   localparam logic [63:0] ZERO_CT = 64'h41EA3A0A_94BAA940;

   logic clk = 1'b0;
   logic rst;
   logic ena;

   tea_iterative_encryptor_if bus();

   tea_iterative_encryptor #(.ROUNDS(ROUNDS), .DELTA(DELTA)) dut (
      .clk (clk),
      .rst (rst),
      .ena (ena),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [63:0]  pt;
      logic [127:0] key;
      logic [63:0]  ct;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   total = 0;
   int   bad   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic flag(input string name);
      total++;
      bad++;
      $display("FAIL %s", name);
   endtask

   function automatic logic [63:0] tea_enc(input logic [63:0] pt, input logic [127:0] k);
      logic [31:0] y;
      logic [31:0] z;
      logic [31:0] s;
      y = pt[63:32];
      z = pt[31:0];
      s = '0;
      for (int i = 0; i < ROUNDS; i++) begin
         s = s + DELTA;
         y = y + (((z << 4) + k[127:96]) ^ (z + s) ^ ((z >> 5) + k[95:64]));
         z = z + (((y << 4) + k[63:32]) ^ (y + s) ^ ((y >> 5) + k[31:0]));
      end
      return {y, z};
   endfunction

   function automatic logic [63:0] tea_dec(input logic [63:0] ct, input logic [127:0] k);
      logic [31:0] y;
      logic [31:0] z;
      logic [31:0] s;
      y = ct[63:32];
      z = ct[31:0];
      s = 32'hC6EF3720;
      for (int i = 0; i < 32; i++) begin
         z = z - (((y << 4) + k[63:32]) ^ (y + s) ^ ((y >> 5) + k[31:0]));
         y = y - (((z << 4) + k[127:96]) ^ (z + s) ^ ((z >> 5) + k[95:64]));
         s = s - DELTA;
      end
      return {y, z};
   endfunction

   // A transfer completes on the next posedge whenever these conditions hold at the negedge.
   always @(negedge clk) begin
      if (!rst && ena && bus.out_valid && bus.out_ready) begin
         if (sb.size() == 0) begin
            flag("unexpected_output");
         end else begin
            mon_e = sb.pop_front();
            check("ciphertext", bus.outBlock64, mon_e.ct);
            check("roundtrip", tea_dec(bus.outBlock64, mon_e.key), mon_e.pt);
         end
      end
   end

   task automatic send(input logic [63:0] pt, input logic [127:0] k, input logic [63:0] ct_exp);
      bit ok;
      ok = 1'b0;
      bus.in_valid  = 1'b1;
      bus.inBlock64 = pt;
      bus.key       = k;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (bus.in_ready) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         flag("accept_timeout");
         bus.in_valid = 1'b0;
         return;
      end
      sb.push_back('{pt, k, ct_exp});
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
   endtask

   task automatic wait_out(output int lat);
      lat = -1;
      for (int i = 1; i <= 200; i++) begin
         @(posedge clk);
         #1;
         if (bus.out_valid) begin
            lat = i;
            return;
         end
      end
   endtask

   task automatic drain();
      for (int i = 0; i < 400; i++) begin
         @(posedge clk);
         if (sb.size() == 0) break;
      end
      #1;
      if (sb.size() != 0) flag("drain_timeout");
   endtask

   logic [63:0]  vec_pt  [6];
   logic [127:0] vec_key [6];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int          lat;
      logic [63:0] ct;
      logic [63:0] pt;
      logic [127:0] k;

      vec_pt[0] = 64'h01234567_89ABCDEF; vec_key[0] = 128'h00112233_44556677_8899AABB_CCDDEEFF;
      vec_pt[1] = 64'hFFFFFFFF_FFFFFFFF; vec_key[1] = 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF;
      vec_pt[2] = 64'h00000000_00000001; vec_key[2] = 128'h0;
      vec_pt[3] = 64'h0;                 vec_key[3] = 128'h00000001_00000000_00000000_00000000;
      vec_pt[4] = 64'hDEADBEEF_CAFEF00D; vec_key[4] = 128'h9E3779B9_7F4A7C15_F39CC060_5CEDC834;
      vec_pt[5] = 64'h80000000_00000000; vec_key[5] = 128'h80000000_80000000_80000000_80000000;

      rst           = 1'b1;
      ena           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      bus.inBlock64 = '0;
      bus.key       = '0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("in_ready_during_rst", 64'(bus.in_ready), 64'd0);
      rst = 1'b0;
      #1;
      check("rst_in_ready", 64'(bus.in_ready), 64'd1);
      check("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("rst_out_block", bus.outBlock64, 64'd0);
      ena = 1'b0;
      #1;
      check("in_ready_ena_low_idle", 64'(bus.in_ready), 64'd0);
      ena = 1'b1;

      // Zero vector with latency
      send(64'd0, 128'd0, ZERO_CT);
      wait_out(lat);
      check("zero_latency", 64'(lat), 64'd32);
      drain();
      check("out_block_retained", bus.outBlock64, ZERO_CT);

      // Directed vectors, back to back
      for (int i = 0; i < 6; i++) send(vec_pt[i], vec_key[i], tea_enc(vec_pt[i], vec_key[i]));
      drain();

      // Further round-trip vectors from simple arithmetic patterns
      for (int i = 1; i <= 10; i++) begin
         pt = {32'h01234567 * 32'(i), ~(32'h89ABCDEF + 32'(i))};
         k  = {32'(i) * 32'h11111111, 32'h0F0F0F0F ^ 32'(i), 32'hA5A5A5A5 + 32'(i), 32'(i) << 20};
         send(pt, k, tea_enc(pt, k));
      end
      drain();

      // Backpressure in DONE
      ct = tea_enc(vec_pt[4], vec_key[0]);
      bus.out_ready = 1'b0;
      send(vec_pt[4], vec_key[0], ct);
      wait_out(lat);
      check("bp_latency", 64'(lat), 64'd32);
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         check("bp_out_block", bus.outBlock64, ct);
         check("bp_out_valid", 64'(bus.out_valid), 64'd1);
         check("bp_in_ready", 64'(bus.in_ready), 64'd0);
      end
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("bp_release_out_valid", 64'(bus.out_valid), 64'd0);
      check("bp_release_in_ready", 64'(bus.in_ready), 64'd1);
      check("bp_release_retained", bus.outBlock64, ct);
      check("bp_sb_empty", 64'(sb.size()), 64'd0);

      // ena stall of 5 cycles after round 10
      send(vec_pt[0], vec_key[4], tea_enc(vec_pt[0], vec_key[4]));
      lat = -1;
      for (int n = 1; n <= 200; n++) begin
         @(posedge clk);
         #1;
         if (bus.out_valid) begin
            lat = n;
            break;
         end
         if (n == 10) begin
            ena = 1'b0;
            #1;
            check("stall_in_ready", 64'(bus.in_ready), 64'd0);
         end
         if (n == 15) ena = 1'b1;
      end
      check("stall_latency", 64'(lat), 64'd37);
      drain();

      // Reset in the middle of a block
      send(vec_pt[1], vec_key[1], tea_enc(vec_pt[1], vec_key[1]));
      repeat (20) @(posedge clk);
      #1 rst = 1'b1;
      #1 check("midrst_in_ready_low", 64'(bus.in_ready), 64'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      #1;
      void'(sb.pop_back());
      check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
      check("midrst_out_block", bus.outBlock64, 64'd0);
      check("midrst_in_ready", 64'(bus.in_ready), 64'd1);
      send(vec_pt[5], vec_key[2], tea_enc(vec_pt[5], vec_key[2]));
      drain();

      // Key and block isolation; in_valid during RUN is ignored
      send(vec_pt[4], vec_key[4], tea_enc(vec_pt[4], vec_key[4]));
      bus.inBlock64 = 64'hBAD0BAD0_BAD0BAD0;
      bus.key       = 128'h55555555_AAAAAAAA_12345678_87654321;
      bus.in_valid  = 1'b1;
      repeat (15) @(posedge clk);
      #1 bus.in_valid = 1'b0;
      drain();
      repeat (40) @(posedge clk);
      #1;
      check("iso_no_extra_block", 64'(bus.out_valid), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
